// File: rtl/cgra_accel.sv
// 16-lane x 32-bit reconfigurable streaming datapath: reads a header (word count),
// a per-lane configuration word, then transforms N data words FIFO-to-FIFO.
module cgra_accel #(
  parameter int LANES = 16,
  parameter int LW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                available_write,
  input  logic                available_read,
  output logic                req_rd_data,
  input  logic [LANES*LW-1:0] rd_data,
  output logic                req_wr_data,
  output logic [LANES*LW-1:0] wr_data,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CFG,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [15:0] imm;
    logic        src;
    logic [3:0]  op;
  } lane_cfg_t;

  state_t                     r_state;
  state_t                     w_next;
  logic      [31:0]           r_n;
  logic      [31:0]           r_rd_cnt;
  logic      [31:0]           r_wr_cnt;
  lane_cfg_t [LANES-1:0]      r_cfg;
  logic      [LANES*LW-1:0]   r_result;
  logic                       r_valid;

  logic                       w_pop;
  logic                       w_push;
  logic                       w_begin;
  logic      [LANES-1:0][LW-1:0] w_lane_res;
  logic      [LW-1:0]         w_a;
  logic      [LW-1:0]         w_b;

  function automatic logic [LW-1:0] lane_alu(input logic [3:0]    op,
                                             input logic [LW-1:0] a,
                                             input logic [LW-1:0] b);
    logic [LW-1:0] res;
    res = '0;
    case (op)
      4'd0:    res = a;
      4'd1:    res = a + b;
      4'd2:    res = a - b;
      4'd3:    res = a * b;
      4'd4:    res = a & b;
      4'd5:    res = a | b;
      4'd6:    res = a ^ b;
      4'd7:    res = a << b[4:0];
      4'd8:    res = a >> b[4:0];
      4'd9:    res = (a < b) ? a : b;
      4'd10:   res = (a > b) ? a : b;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Lane i pairs with lane i+1 as its neighbour operand; lane 15 wraps to lane 0.
  always_comb begin
    w_a        = '0;
    w_b        = '0;
    w_lane_res = '0;
    for (int i = 0; i < LANES; i++) begin
      w_a = rd_data[i*LW +: LW];
      w_b = r_cfg[i].src ? rd_data[((i + 1) % LANES)*LW +: LW]
                         : {{(LW-16){1'b0}}, r_cfg[i].imm};
      w_lane_res[i] = lane_alu(r_cfg[i].op, w_a, w_b);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_push = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = S_HDR;
      end
      S_HDR: begin
        w_pop = available_read;
        if (available_read) w_next = S_CFG;
      end
      S_CFG: begin
        w_pop = available_read;
        if (available_read) w_next = (r_n == 32'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_push = r_valid & available_write;
        w_pop  = available_read & (r_rd_cnt < r_n) & (~r_valid | available_write);
        if (w_push && (r_wr_cnt == r_n - 32'd1)) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_begin     = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign req_rd_data = w_pop;
  assign req_wr_data = w_push;
  assign wr_data     = r_result;
  assign done        = (r_state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_begin) begin
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
        r_valid  <= 1'b0;
      end
      if ((r_state == S_HDR) && w_pop) r_n <= rd_data[31:0];
      if (r_state == S_RUN) begin
        if (w_pop) begin
          r_result <= w_lane_res;
          r_valid  <= 1'b1;
          r_rd_cnt <= r_rd_cnt + 32'd1;
        end else if (w_push) begin
          r_valid <= 1'b0;
        end
        if (w_push) r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

  // NOTE: lane configuration is left unreset; it is always loaded in CFG before RUN can use it.
  always_ff @(posedge clk) begin
    if ((r_state == S_CFG) && w_pop) begin
      for (int i = 0; i < LANES; i++) begin
        r_cfg[i].imm <= rd_data[i*LW + 16 +: 16];
        r_cfg[i].src <= rd_data[i*LW + 4];
        r_cfg[i].op  <= rd_data[i*LW +: 4];
      end
    end
  end

endmodule

// File: tb/tb_cgra_accel.sv
// Directed bench for cgra_accel: table of single-word lane-op vectors plus
// hand-written sequences for streaming, backpressure, N=0 and mid-run reset.
module tb_cgra_accel;

  logic         clk;
  logic         rst;
  logic         start;
  logic         available_write;
  logic         available_read;
  logic         req_rd_data;
  logic [511:0] rd_data;
  logic         req_wr_data;
  logic [511:0] wr_data;
  logic         done;

  cgra_accel dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .available_write (available_write),
    .available_read  (available_read),
    .req_rd_data     (req_rd_data),
    .rd_data         (rd_data),
    .req_wr_data     (req_wr_data),
    .wr_data         (wr_data),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cfg;
    logic [31:0] base;
    logic [31:0] step;
    logic [31:0] exp0;
    logic [31:0] exp15;
  } vec_t;

  vec_t         vecs [14];
  logic [511:0] in_q [$];
  logic [511:0] out_q[$];
  bit           feed_en;
  bit           last_rd;
  bit           last_wr;
  int           checks;
  int           errors;
  int           pops;
  int           pushes;
  int           job_pops0;
  int           job_pushes0;
  int           max_gap;

  function automatic logic [31:0] mk_cfg(input logic [3:0] op, input logic src, input logic [15:0] imm);
    return {imm, 11'd0, src, op};
  endfunction

  function automatic logic [511:0] seq(input logic [31:0] base, input logic [31:0] step);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = base + step * 32'(i);
    return w;
  endfunction

  function automatic logic [511:0] out_word(input int k);
    return (out_q.size() > k) ? out_q[k] : '0;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: present the FIFO head, record handshakes that the next edge commits, step to next negedge.
  task automatic tick();
    int gap;
    available_read = feed_en && (in_q.size() > 0);
    rd_data        = (in_q.size() > 0) ? in_q[0] : '0;
    #1;
    last_rd = !rst && req_rd_data;
    last_wr = !rst && req_wr_data;
    if (last_wr) begin
      out_q.push_back(wr_data);
      pushes++;
    end
    if (last_rd) begin
      void'(in_q.pop_front());
      pops++;
    end
    gap = (pops - job_pops0 - 2) - (pushes - job_pushes0);
    if (gap > max_gap) max_gap = gap;
    @(negedge clk);
  endtask

  task automatic new_job(input logic [31:0] n, input logic [31:0] cfg);
    in_q.delete();
    out_q.delete();
    in_q.push_back({480'd0, n});
    in_q.push_back({16{cfg}});
    job_pops0   = pops;
    job_pushes0 = pushes;
    max_gap     = -2;
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check_int({name, "_done"}, int'(done), 1);
  endtask

  initial begin
    logic [511:0] exp_w;
    logic [511:0] held;
    int           snap;
    int           k;

    vecs[0]  = '{mk_cfg(4'd0,  1'b0, 16'h0000), 32'd7,         32'd1, 32'd7,         32'd22};
    vecs[1]  = '{mk_cfg(4'd1,  1'b0, 16'h0010), 32'd1,         32'd1, 32'h11,        32'h20};
    vecs[2]  = '{mk_cfg(4'd3,  1'b0, 16'h0002), 32'h80000001,  32'd0, 32'd2,         32'd2};
    vecs[3]  = '{mk_cfg(4'd4,  1'b0, 16'hFF0F), 32'h1234ABCD,  32'd0, 32'h0000AB0D,  32'h0000AB0D};
    vecs[4]  = '{mk_cfg(4'd5,  1'b0, 16'h00F0), 32'hA0000001,  32'd0, 32'hA00000F1,  32'hA00000F1};
    vecs[5]  = '{mk_cfg(4'd6,  1'b1, 16'h0000), 32'd5,         32'd1, 32'd3,         32'd17};
    vecs[6]  = '{{16'h0024, 11'h7FF, 1'b0, 4'd7}, 32'd1,      32'd1, 32'd16,        32'd256};
    vecs[7]  = '{mk_cfg(4'd8,  1'b1, 16'h0000), 32'hF0000000,  32'd1, 32'h78000000,  32'hF000000F};
    vecs[8]  = '{mk_cfg(4'd9,  1'b1, 16'h0000), 32'd10,        32'd1, 32'd10,        32'd10};
    vecs[9]  = '{mk_cfg(4'd10, 1'b0, 16'd20),   32'd10,        32'd1, 32'd20,        32'd25};
    vecs[10] = '{mk_cfg(4'd11, 1'b0, 16'hFFFF), 32'd3,         32'd1, 32'd0,         32'd0};
    vecs[11] = '{mk_cfg(4'd2,  1'b0, 16'h0001), 32'd0,         32'd0, 32'hFFFFFFFF,  32'hFFFFFFFF};
    vecs[12] = '{mk_cfg(4'd15, 1'b1, 16'h0000), 32'd9,         32'd2, 32'd0,         32'd0};
    vecs[13] = '{mk_cfg(4'd3,  1'b1, 16'h0000), 32'd3,         32'd1, 32'd12,        32'd54};

    checks = 0; errors = 0; pops = 0; pushes = 0;
    job_pops0 = 0; job_pushes0 = 0; max_gap = 0;
    rst = 1'b1; start = 1'b0; available_write = 1'b1; available_read = 1'b0;
    rd_data = '0; feed_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    check("reset_wr_data", wr_data, '0);
    check_int("reset_ctrl", int'({req_rd_data, req_wr_data, done}), 0);

    // Idle with data available and no start: nothing may be popped.
    in_q.push_back(seq(32'd1, 32'd1));
    feed_en = 1'b1;
    snap = pops;
    for (int i = 0; i < 5; i++) tick();
    check_int("idle_no_pop", pops - snap, 0);
    check_int("idle_req_rd", int'(req_rd_data), 0);
    check_int("idle_done", int'(done), 0);

    // N=2, add immediate 5.
    new_job(32'd2, mk_cfg(4'd1, 1'b0, 16'd5));
    in_q.push_back(seq(32'd0, 32'd1));
    in_q.push_back(seq(32'd100, 32'd1));
    start_job();
    run_until_done("add_imm", 50);
    check_int("add_imm_pushes", out_q.size(), 2);
    check("add_imm_w0", out_word(0), seq(32'd5, 32'd1));
    check("add_imm_w1", out_word(1), seq(32'd105, 32'd1));
    check_int("add_imm_done_after_push", int'(last_wr), 1);

    // Neighbour subtract with wrap-around.
    new_job(32'd1, mk_cfg(4'd2, 1'b1, 16'd0));
    in_q.push_back(seq(32'd0, 32'd3));
    start_job();
    run_until_done("sub_nb", 50);
    for (int i = 0; i < 15; i++) exp_w[i*32 +: 32] = 32'hFFFFFFFD;
    exp_w[511:480] = 32'd45;
    check("sub_nb_w0", out_word(0), exp_w);

    // Table of single-word lane-op vectors.
    for (int i = 0; i < 14; i++) begin
      new_job(32'd1, vecs[i].cfg);
      in_q.push_back(seq(vecs[i].base, vecs[i].step));
      start_job();
      run_until_done($sformatf("vec%0d", i), 50);
      exp_w = out_word(0);
      check($sformatf("vec%0d_lanes", i), {exp_w[511:480], exp_w[31:0]},
            {vecs[i].exp15, vecs[i].exp0});
    end

    // Backpressure: N=4, output blocked while the first result is held.
    available_write = 1'b0;
    new_job(32'd4, mk_cfg(4'd0, 1'b0, 16'd0));
    for (int j = 0; j < 4; j++) in_q.push_back(seq(32'h100 * 32'(j + 1), 32'd1));
    start_job();
    k = 0;
    while ((pops - job_pops0) < 3 && k < 20) begin
      tick();
      k++;
    end
    check_int("bp_first_pop", pops - job_pops0, 3);
    held = wr_data;
    check("bp_first_result", held, seq(32'h100, 32'd1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), wr_data, held);
    end
    check_int("bp_stalled_reads", pops - job_pops0, 3);
    check_int("bp_no_push", pushes - job_pushes0, 0);
    available_write = 1'b1;
    run_until_done("bp", 50);
    check_int("bp_pushes", out_q.size(), 4);
    for (int j = 0; j < 4; j++)
      check($sformatf("bp_w%0d", j), out_word(j), seq(32'h100 * 32'(j + 1), 32'd1));
    check_int("bp_read_ahead_le1", int'(max_gap <= 1), 1);

    // N=0: header and config only, spare word must stay in the FIFO.
    new_job(32'd0, mk_cfg(4'd1, 1'b0, 16'd5));
    in_q.push_back(seq(32'd7, 32'd0));
    start_job();
    run_until_done("n0", 20);
    check_int("n0_pops", pops - job_pops0, 2);
    check_int("n0_pushes", pushes - job_pushes0, 0);
    check_int("n0_done_on_cfg_pop", int'(last_rd), 1);
    check_int("n0_spare_left", in_q.size(), 1);

    // Reset after the first of three results.
    new_job(32'd3, mk_cfg(4'd1, 1'b0, 16'd1));
    for (int j = 0; j < 3; j++) in_q.push_back(seq(32'd16 * 32'(j), 32'd1));
    start_job();
    k = 0;
    while ((pushes - job_pushes0) < 1 && k < 20) begin
      tick();
      k++;
    end
    check("rst_first_result", out_word(0), seq(32'd1, 32'd1));
    rst = 1'b1;
    tick();
    check("rst_wr_data", wr_data, '0);
    check_int("rst_ctrl", int'({req_rd_data, req_wr_data, done}), 0);
    rst = 1'b0;
    snap = pops + pushes;
    for (int i = 0; i < 4; i++) tick();
    check_int("rst_no_activity", pops + pushes - snap, 0);
    new_job(32'd1, mk_cfg(4'd6, 1'b0, 16'hFFFF));
    in_q.push_back(seq(32'hABCD0000, 32'd1));
    start_job();
    run_until_done("after_rst", 50);
    check_int("after_rst_pushes", out_q.size(), 1);
    check("after_rst_w0", out_word(0), seq(32'hABCDFFFF, 32'hFFFFFFFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
